mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit controller with HI/LO write-back.
//
// Accepts one request at a time while idle and produces a HI/LO write:
//   MTHI/MTLO  : written combinationally in the accept cycle (no state change)
//   MULT/MULTU : 32x32 product registered in MUL, written from DONE (T+2)
//   DIV/DIVU   : restoring radix-2 divide, 32 iterations in DIV, DONE at T+33
//   op 6/7     : accepted and dropped
// flush aborts any in-flight operation; reset aborts and blanks all outputs.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   req_valid, req_op[2:0]: request handshake and opcode
//   req_a, req_b [31:0]   : operands (a = dividend/multiplicand/MT source)
//   req_ready             : request accepted when req_valid & req_ready
//   flush                 : abort in-flight operation / block acceptance
//   busy                  : high whenever the FSM is not idle
//   hi_write, lo_write    : HI/LO write enables
//   hi_data, lo_data      : HI/LO write data (zero while enable low)
//   done                  : one-cycle completion pulse
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        busy,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data,
  output logic        done
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [31:0] a_reg, b_reg;
  logic [31:0] dvsr_reg;     // divisor magnitude
  logic [4:0]  cnt_reg;
  // During a divide res_lo_reg doubles as the dividend/quotient shift
  // register and res_hi_reg as the partial remainder.
  logic [31:0] res_hi_reg, res_lo_reg;

  logic accept;
  assign accept = (state_reg == IDLE) && req_valid && !flush && !reset;

  // ---------------- acceptance-time operand magnitudes ----------------
  logic        in_div_signed;
  logic [31:0] in_a_mag, in_b_mag;
  assign in_div_signed = (req_op == OP_DIV);
  assign in_a_mag = (in_div_signed && req_a[31]) ? (32'd0 - req_a) : req_a;
  assign in_b_mag = (in_div_signed && req_b[31]) ? (32'd0 - req_b) : req_b;

  // ---------------- multiplier ----------------
  // Operands are extended to 64 bits so the low 64 bits of the product are
  // the exact signed or unsigned result.
  logic        mul_signed;
  logic [63:0] mul_a_ext, mul_b_ext, product;
  assign mul_signed = (op_reg == OP_MULT);
  assign mul_a_ext  = {(mul_signed ? {32{a_reg[31]}} : 32'd0), a_reg};
  assign mul_b_ext  = {(mul_signed ? {32{b_reg[31]}} : 32'd0), b_reg};
  assign product    = mul_a_ext * mul_b_ext;

  // ---------------- divider step ----------------
  logic [32:0] r_shift;
  logic        r_ge;
  logic [31:0] r_sub, r_next, q_next;
  assign r_shift = {res_hi_reg, res_lo_reg[31]};
  assign r_ge    = (r_shift >= {1'b0, dvsr_reg});
  assign r_sub   = r_shift[31:0] - dvsr_reg;   // exact whenever r_ge
  assign r_next  = r_ge ? r_sub : r_shift[31:0];
  assign q_next  = {res_lo_reg[30:0], r_ge};

  // Sign fix-up applied on the last iteration. Divide-by-zero is forced to
  // the fixed pattern rather than relying on the raw iteration result,
  // which would otherwise be sign-adjusted for negative signed dividends.
  logic        div_signed, q_neg, r_neg;
  logic [31:0] q_final, r_final;
  assign div_signed = (op_reg == OP_DIV);
  assign q_neg = div_signed && (a_reg[31] ^ b_reg[31]);
  assign r_neg = div_signed && a_reg[31];

  always_comb begin
    q_final = q_neg ? (32'd0 - q_next) : q_next;
    r_final = r_neg ? (32'd0 - r_next) : r_next;
    if (b_reg == 32'd0) begin
      q_final = 32'hFFFF_FFFF;
      r_final = a_reg;
    end
  end

  // ---------------- FSM state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // ---------------- FSM next state / outputs ----------------
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    busy       = 1'b0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
    hi_data    = 32'd0;
    lo_data    = 32'd0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          case (req_op)
            OP_MULT, OP_MULTU: state_next = MUL;
            OP_DIV,  OP_DIVU:  state_next = DIV;
            OP_MTHI: begin
              hi_write = 1'b1;
              hi_data  = req_a;
              done     = 1'b1;
            end
            OP_MTLO: begin
              lo_write = 1'b1;
              lo_data  = req_a;
              done     = 1'b1;
            end
            default: ;   // reserved: accepted and dropped
          endcase
        end
      end
      MUL: begin
        busy       = 1'b1;
        state_next = flush ? IDLE : DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (flush)                 state_next = IDLE;
        else if (cnt_reg == 5'd31) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
        if (!flush) begin
          hi_write = 1'b1;
          lo_write = 1'b1;
          hi_data  = res_hi_reg;
          lo_data  = res_lo_reg;
          done     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Reset overrides everything, including a concurrent request or flush.
    if (reset) begin
      state_next = IDLE;
      req_ready  = 1'b0;
      busy       = 1'b0;
      hi_write   = 1'b0;
      lo_write   = 1'b0;
      hi_data    = 32'd0;
      lo_data    = 32'd0;
      done       = 1'b0;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg     <= 3'd0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      dvsr_reg   <= 32'd0;
      cnt_reg    <= 5'd0;
      res_hi_reg <= 32'd0;
      res_lo_reg <= 32'd0;
    end else if (accept) begin
      op_reg  <= req_op;
      a_reg   <= req_a;
      b_reg   <= req_b;
      cnt_reg <= 5'd0;
      if (req_op == OP_DIV || req_op == OP_DIVU) begin
        res_lo_reg <= in_a_mag;
        res_hi_reg <= 32'd0;
        dvsr_reg   <= in_b_mag;
      end
    end else if (state_reg == MUL && !flush) begin
      res_hi_reg <= product[63:32];
      res_lo_reg <= product[31:0];
    end else if (state_reg == DIV && !flush) begin
      cnt_reg <= cnt_reg + 5'd1;
      if (cnt_reg == 5'd31) begin
        res_lo_reg <= q_final;
        res_hi_reg <= r_final;
      end else begin
        res_lo_reg <= q_next;
        res_hi_reg <= r_next;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl -- directed self-checking bench for mdu_ctrl.
// Inputs are driven just after the falling edge and outputs are sampled
// 1 time unit later, well away from the rising edge.
module tb_mdu_ctrl;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // flag vector order: {req_ready, busy, done, hi_write, lo_write}
  localparam logic [4:0] F_IDLE = 5'b10000;
  localparam logic [4:0] F_BUSY = 5'b01000;
  localparam logic [4:0] F_DONE = 5'b01111;
  localparam logic [4:0] F_NONE = 5'b00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready;
  logic        flush;
  logic        busy;
  logic        hi_write, lo_write;
  logic [31:0] hi_data, lo_data;
  logic        done;
  logic [4:0]  fl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign fl = {req_ready, busy, done, hi_write, lo_write};

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .flush     (flush),
    .busy      (busy),
    .hi_write  (hi_write),
    .lo_write  (lo_write),
    .hi_data   (hi_data),
    .lo_data   (lo_data),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one MULT/DIV-class op, hammer the request port with a junk MTHI
  // while busy, and check the result in the DONE cycle at T+lat.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; #1;
    check({tag, " accept"}, fl, F_IDLE);
    tick;
    for (int k = 1; k < lat; k++) begin
      req_valid = 1'b1; req_op = OP_MTHI; req_a = $urandom; req_b = $urandom; #1;
      check({tag, " busy"}, fl, F_BUSY);
      tick;
    end
    req_valid = 1'b0; #1;
    check({tag, " done flags"}, fl, F_DONE);
    check({tag, " hi"}, hi_data, ehi);
    check({tag, " lo"}, lo_data, elo);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, hi_data, lo_data);
    tick; #1;
    check({tag, " back idle"}, fl, F_IDLE);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'h1; req_b = 32'h0; flush = 1'b0;
    @(negedge clk); #1;
    // reset beats a concurrent MTHI request
    check("reset flags", fl, F_NONE);
    check("reset hi_data", hi_data, 0);
    tick;
    reset = 1'b0; req_valid = 1'b0; #1;
    check("post-reset idle", fl, F_IDLE);

    run_op("mult -3*5",   OP_MULT,  32'hFFFF_FFFD, 32'd5,         2, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult mixed",  OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 2, 32'hC000_0000, 32'h8000_0000);
    run_op("div -7/2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/0",    OP_DIVU,  32'd7,         32'd0,         33, 32'd7,         32'hFFFF_FFFF);
    run_op("div -7/0",    OP_DIV,   32'hFFFF_FFF9, 32'd0,         33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divu 100/7",  OP_DIVU,  32'd100,       32'd7,         33, 32'd2,         32'd14);
    run_op("div 7/-2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'd1,         32'hFFFF_FFFD);
    run_op("div -7/-2",   OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFF, 32'd3);

    // MTHI blocked by flush, then accepted
    req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'hABCD; flush = 1'b1; #1;
    check("mthi flushed flags", fl, F_NONE);
    flush = 1'b0; #1;
    check("mthi flags", fl, 5'b10110);
    check("mthi hi_data", hi_data, 32'hABCD);
    check("mthi lo_data", lo_data, 0);
    $display("op=%0d a=%h -> hi=%h", OP_MTHI, req_a, hi_data);
    tick;
    req_valid = 1'b0; #1;
    check("mthi stays idle", fl, F_IDLE);

    // reserved op is swallowed
    req_valid = 1'b1; req_op = 3'd6; req_a = 32'h5; #1;
    check("reserved flags", fl, F_IDLE);
    tick;
    req_valid = 1'b0; #1;
    check("reserved idle", fl, F_IDLE);
    $display("op=6 reserved dropped");

    // flush during DIV at T+10
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd100; req_b = 32'd3; #1;
    check("divflush accept", fl, F_IDLE);
    tick;
    req_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      #1; check("divflush busy", fl, F_BUSY); tick;
    end
    flush = 1'b1; #1;
    check("divflush flush cycle", fl, F_BUSY);
    tick;
    flush = 1'b0;
    for (int k = 11; k <= 40; k++) begin
      #1; check("divflush quiet", fl, F_IDLE); tick;
    end
    req_valid = 1'b1; req_op = OP_MTLO; req_a = 32'h1234; #1;
    check("mtlo flags", fl, 5'b10101);
    check("mtlo lo_data", lo_data, 32'h1234);
    $display("op=%0d a=%h -> lo=%h (after flushed div)", OP_MTLO, req_a, lo_data);
    tick;
    req_valid = 1'b0;

    // flush in MUL and in DONE
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd4; #1;
    tick;
    req_valid = 1'b0; flush = 1'b1; #1;
    check("mulflush in MUL", fl, F_BUSY);
    tick;
    flush = 1'b0; #1;
    check("mulflush idle", fl, F_IDLE);
    req_valid = 1'b1; #1;
    tick;
    req_valid = 1'b0; #1;
    tick;
    flush = 1'b1; #1;
    check("doneflush flags", fl, F_BUSY);
    check("doneflush hi_data", hi_data, 0);
    tick;
    flush = 1'b0; #1;
    check("doneflush idle", fl, F_IDLE);
    $display("mult flushed in MUL and in DONE");

    // reset pulsed at T+5 of a DIV, with a concurrent request and flush
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd50; req_b = 32'd5; #1;
    tick;
    req_valid = 1'b0;
    for (int k = 1; k < 5; k++) tick;
    reset = 1'b1; req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'h55; flush = 1'b1; #1;
    check("midreset flags", fl, F_NONE);
    check("midreset hi_data", hi_data, 0);
    check("midreset lo_data", lo_data, 0);
    tick;
    reset = 1'b0; req_valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 35; k++) begin
      #1; check("midreset quiet", fl, F_IDLE); tick;
    end
    $display("div aborted by reset");
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
